// File: rtl/game_judge_pkg.sv
// game_judge_pkg: shared cell/result codes, sizes and FSM states for the tic-tac-toe judge.
package game_judge_pkg;
  localparam int BOARD_W = 18;
  localparam int CELLS   = 9;
  localparam int LINES   = 8;
  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] CELL_ILL   = 2'b11;
  localparam logic [1:0] RES_PLAY   = 2'b00;
  localparam logic [1:0] RES_P1     = 2'b01;
  localparam logic [1:0] RES_P2     = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;
  typedef enum logic [1:0] {IDLE, SCAN, FULLCHK, DONE} state_e;
endpackage

// File: rtl/game_judge_line_eval.sv
// line_eval: a line wins when its three cells hold the same nonblank code.
module line_eval
  import game_judge_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] c_i,
  output logic       win_o,
  output logic [1:0] winner_o
);
  assign win_o    = (a_i != CELL_BLANK) && (a_i == b_i) && (b_i == c_i);
  assign winner_o = a_i;
endmodule

// File: rtl/game_judge.sv
// game_judge: snapshots a board on start and scans its eight lines one per cycle.
module game_judge
  import game_judge_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BOARD_W-1:0] board,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [2:0]         win_line,
  output logic               error
);
  localparam logic [3:0] LINE_CELLS [LINES][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}};
  state_e             state_q, state_d;
  logic [BOARD_W-1:0] snap_q, snap_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         result_q, result_d;
  logic [2:0]         line_q, line_d;
  logic               error_q, error_d;
  logic               ill, full, win;
  logic [1:0]         winner;
  always_comb begin
    ill  = 1'b0;
    full = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      ill  = ill | (&snap_q[2*i +: 2]);
      full = full & (|snap_q[2*i +: 2]);
    end
  end
  line_eval u_line_eval (
    .a_i     (snap_q[{LINE_CELLS[cnt_q][0], 1'b0} +: 2]),
    .b_i     (snap_q[{LINE_CELLS[cnt_q][1], 1'b0} +: 2]),
    .c_i     (snap_q[{LINE_CELLS[cnt_q][2], 1'b0} +: 2]),
    .win_o   (win),
    .winner_o(winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      cnt_q    <= '0;
      result_q <= RES_PLAY;
      line_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      line_q   <= line_d;
      error_q  <= error_d;
    end
  end
  // Outputs are rewritten only on entry to DONE so they hold between judgements.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    line_d   = line_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: if (start) begin
        snap_d  = board;
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: if (cnt_q == 3'd0 && ill) begin
        state_d  = DONE;
        error_d  = 1'b1;
        result_d = RES_PLAY;
        line_d   = '0;
      end else if (win) begin
        state_d  = DONE;
        error_d  = 1'b0;
        result_d = winner;
        line_d   = cnt_q;
      end else if (cnt_q == 3'd7) begin
        state_d = FULLCHK;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      FULLCHK: begin
        state_d  = DONE;
        error_d  = 1'b0;
        result_d = full ? RES_DRAW : RES_PLAY;
        line_d   = '0;
      end
      DONE: state_d = IDLE;
    endcase
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign win_line = line_q;
  assign error    = error_q;
endmodule

// File: tb/tb_game_judge.sv
// tb_game_judge: directed vector table plus hand sequences for busy-start, mid-scan board change and reset.
module tb_game_judge;
  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] board;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  result;
  logic [2:0]  win_line;
  int checks = 0;
  int errors = 0;

  game_judge dut (
    .clk     (clk),
    .reset   (reset),
    .board   (board),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .win_line(win_line),
    .error   (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] brd;
    int          lat;
    logic [1:0]  res;
    logic [2:0]  line;
    logic        err;
  } vec_t;

  function automatic logic [17:0] b9(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // k counts cycles after the start edge: the first negedge afterwards is cycle t+1.
  task automatic wait_done(inout int k);
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    board = v.brd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk({v.name, "_busy"}, busy, 1'b1);
    wait_done(k);
    chk({v.name, "_latency"}, k, v.lat);
    chk({v.name, "_result"}, result, v.res);
    chk({v.name, "_line"}, win_line, v.line);
    chk({v.name, "_error"}, error, v.err);
    @(negedge clk);
    chk({v.name, "_idle"}, {busy, done}, 2'b00);
    @(negedge clk);
    chk({v.name, "_hold"}, {result, win_line, error}, {v.res, v.line, v.err});
  endtask

  localparam logic [1:0] B = 2'b00, X = 2'b01, O = 2'b10, I = 2'b11;
  vec_t vecs[9];

  initial begin
    int k;
    int seen;
    logic [17:0] row0, anti, draw;
    row0 = b9(X, X, X, B, B, B, B, B, B);
    anti = b9(X, X, O, B, O, B, O, B, B);
    draw = b9(X, O, X, X, O, O, O, X, X);
    vecs[0] = '{"row0",    row0, 2, 2'b01, 3'd0, 1'b0};
    vecs[1] = '{"anti",    anti, 9, 2'b10, 3'd7, 1'b0};
    vecs[2] = '{"draw",    draw, 10, 2'b11, 3'd0, 1'b0};
    vecs[3] = '{"inplay",  b9(X, O, X, X, O, O, O, X, B), 10, 2'b00, 3'd0, 1'b0};
    vecs[4] = '{"illegal", b9(B, B, B, B, B, I, B, B, B), 2, 2'b00, 3'd0, 1'b1};
    vecs[5] = '{"col1",    b9(B, O, B, B, O, B, B, O, B), 6, 2'b10, 3'd4, 1'b0};
    vecs[6] = '{"prio",    b9(X, B, B, X, B, B, X, X, X), 4, 2'b01, 3'd2, 1'b0};
    vecs[7] = '{"empty",   '0, 10, 2'b00, 3'd0, 1'b0};
    vecs[8] = '{"ill_win", b9(B, B, B, X, X, X, B, B, I), 2, 2'b00, 3'd0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    board = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, result, win_line, error}, '0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Restart during busy is ignored and a mid-scan board change is not seen.
    @(negedge clk);
    board = anti;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 3) begin
      @(negedge clk);
      k++;
    end
    board = row0;
    start = 1'b1;
    @(negedge clk);
    k++;
    start = 1'b0;
    wait_done(k);
    chk("midscan_latency", k, 9);
    chk("midscan_result", result, 2'b10);
    chk("midscan_line", win_line, 3'd7);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("busy_start_not_queued", seen, 0);

    // Reset during a scan aborts it with no done pulse.
    run_vec(vecs[0]);
    @(negedge clk);
    board = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 4) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_outputs", {busy, done, result, win_line, error}, '0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    board = row0;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("reset_over_start", busy, 1'b0);
    @(negedge clk);
    chk("reset_over_start_after", {busy, done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_judge.md
GAME_JUDGE -- requirements
Module: game_judge

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: board  in  18  flattened board; cell i (i = 3*row+col, 0..8) at bits [2i+1:2i].
REQ-004 SHALL provide: start  in  1  one-cycle request to judge the current board; sampled only while busy=0.
REQ-005 SHALL provide: busy  out  1  judgement in progress.
REQ-006 SHALL provide: done  out  1  one-cycle pulse; result, win_line and error valid from this cycle.
REQ-007 SHALL provide: result  out  2  00 in-play, 01 player-1 win, 10 player-2 win, 11 draw.
REQ-008 SHALL provide: win_line  out  3  winning line: 0-2 rows, 3-5 columns, 6 main diagonal (0,4,8), 7 anti-diagonal (2,4,6); 0 when no win.
REQ-009 SHALL provide: error  out  1  snapshot held a cell code 11.

Function
REQ-010 Cell codes SHALL be: 00 blank, 01 player 1, 10 player 2, 11 illegal.
REQ-011 FSM states SHALL be IDLE, SCAN, FULLCHK, DONE.
REQ-012 IDLE: start=1 at edge t SHALL copy board into an internal snapshot, clear the line counter and enter SCAN; busy=1 from cycle t+1.
REQ-013 Changes on board after the start edge SHALL NOT affect the judgement in progress.
REQ-014 First SCAN cycle SHALL check the snapshot for any cell code 11; if found, go to DONE with error=1, result=00, win_line=0 (done in cycle t+2).
REQ-015 SCAN SHALL evaluate one line per cycle, index 0..7 ascending; line k is evaluated in cycle t+1+k.
REQ-016 A line SHALL win when all three cells are equal and nonblank; winner code is the cell code.
REQ-017 On the first winning line k, SCAN SHALL latch result=winner and win_line=k, then go to DONE (done in cycle t+2+k); lower-indexed lines take priority.
REQ-018 After line 7 with no win, the FSM SHALL enter FULLCHK (cycle t+9).
REQ-019 FULLCHK SHALL set result=11 if no snapshot cell is blank, else 00; win_line=0; then go to DONE (done in cycle t+10).
REQ-020 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-021 start while busy=1 (SCAN, FULLCHK or DONE) SHALL be ignored, not queued.
REQ-022 result, win_line and error SHALL hold their values from DONE until the next DONE.
REQ-023 The line counter SHALL be 3 bits and SHALL NOT wrap; SCAN exits at index 7.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE and clear busy, done, result, win_line, error, snapshot and line counter to 0.
REQ-025 reset SHALL override start when both are high in the same cycle.
REQ-026 reset during SCAN or FULLCHK SHALL abort the judgement with no done pulse.

Structure
REQ-027 The shared defines file SHALL hold: cell codes, result codes, board width (18), cell count (9), line count (8).
REQ-028 The 8x3 line-to-cell index table SHALL be a constant in game_judge.
REQ-029 One combinational sub-module, line_eval, SHALL take three 2-bit cells and return win flag plus winner code.

Verification
REQ-030 Row win: board cells 0,1,2=01, rest 00, start -> done at t+2, result=01, win_line=0.
REQ-031 Anti-diagonal: cells 2,4,6=10, cells 0,1=01 -> done at t+9, result=10, win_line=7.
REQ-032 Draw: board X O X / X O O / O X X (01 10 01 / 01 10 10 / 10 01 01) -> done at t+10, result=11; same board with cell 8=00 -> result=00.
REQ-033 Illegal: cell 5=11 -> done at t+2, error=1, result=00; second start during busy ignored; board changed mid-scan does not alter result.
REQ-034 Reset: assert reset at t+4 of a scan -> no done pulse, all outputs 0 next cycle; start and reset in the same cycle -> busy stays 0.
